ppt_multi_channel: RTL

//   Next-generation pulse-train generator: N_CH independent channels, each with

---
 rtl/ppt_multi_channel.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ppt_multi_channel.sv
// ppt_multi_channel: N_CH independent pulse-train generators sharing one
// power-of-two prescaler tick, with shadowed configuration and count readback.
module ppt_multi_channel #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 14,
    parameter int BURST_W = 8,
    parameter int DIV_W   = 5,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DIV_W-1:0]   div_sel_i,
    input  logic               cfg_wr_i,
    input  logic [CH_W-1:0]    cfg_ch_i,
    input  logic [1:0]         cfg_sel_i,
    input  logic [CNT_W-1:0]   cfg_data_i,
    input  logic [N_CH-1:0]    start_i,
    input  logic [N_CH-1:0]    stop_i,
    input  logic [CH_W-1:0]    rd_ch_i,
    output logic [N_CH-1:0]    pulse_out_o,
    output logic [N_CH-1:0]    busy_o,
    output logic [N_CH-1:0]    done_o,
    output logic [BURST_W-1:0] rd_count_o
);

    localparam int PS_W = (1 << DIV_W) - 1;

    typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, DONE} state_e;

    logic [PS_W-1:0]    prescale_q;
    logic [PS_W-1:0]    tickMask;
    logic               tick;

    logic [CNT_W-1:0]   shPeriod_q [N_CH];
    logic [CNT_W-1:0]   shWidth_q  [N_CH];
    logic [CNT_W-1:0]   shDelay_q  [N_CH];
    logic [BURST_W-1:0] shBurst_q  [N_CH];
    logic [BURST_W-1:0] countArr   [N_CH];

    // The counter is as wide as the largest div_sel, so large selects simply saturate.
    assign tickMask = ~({PS_W{1'b1}} << div_sel_i);
    assign tick     = &(prescale_q | ~tickMask);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                shPeriod_q[i] <= '0;
                shWidth_q[i]  <= '0;
                shDelay_q[i]  <= '0;
                shBurst_q[i]  <= '0;
            end
        end else if (cfg_wr_i && (int'(cfg_ch_i) < N_CH)) begin
            case (cfg_sel_i)
                2'd0:    shPeriod_q[cfg_ch_i] <= cfg_data_i;
                2'd1:    shWidth_q[cfg_ch_i]  <= cfg_data_i;
                2'd2:    shDelay_q[cfg_ch_i]  <= cfg_data_i;
                default: shBurst_q[cfg_ch_i]  <= cfg_data_i[BURST_W-1:0];
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_e             state_q, state_d;
        logic [CNT_W-1:0]   period_q, width_q, delay_q;
        logic [BURST_W-1:0] burst_q;
        logic [CNT_W-1:0]   timer_q, timer_d;
        logic [BURST_W-1:0] count_q, count_d;
        logic               pulse_q, busy_q, done_q;
        logic               pulse_d, busy_d, done_d;
        logic [CNT_W-1:0]   selPeriod, selWidth, selDelay;
        logic [CNT_W-1:0]   hiLen, loLen;
        logic               startOk, newPeriod, periodEnd;

        // On an accepted start the shadow values steer the transition before they land in the active regs.
        assign startOk   = start_i[g] && !stop_i[g] && ((state_q == IDLE) || (state_q == DONE));
        assign selPeriod = startOk ? shPeriod_q[g] : period_q;
        assign selWidth  = startOk ? shWidth_q[g]  : width_q;
        assign selDelay  = startOk ? shDelay_q[g]  : delay_q;
        assign hiLen     = (selWidth >= selPeriod) ? selPeriod : selWidth;
        assign loLen     = selPeriod - hiLen;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q  <= IDLE;
                timer_q  <= '0;
                count_q  <= '0;
                period_q <= '0;
                width_q  <= '0;
                delay_q  <= '0;
                burst_q  <= '0;
                pulse_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                count_q <= count_d;
                pulse_q <= pulse_d;
                busy_q  <= busy_d;
                done_q  <= done_d;
                if (startOk) begin
                    period_q <= shPeriod_q[g];
                    width_q  <= shWidth_q[g];
                    delay_q  <= shDelay_q[g];
                    burst_q  <= shBurst_q[g];
                end
            end
        end

        always_comb begin
            state_d   = state_q;
            timer_d   = timer_q;
            count_d   = count_q;
            newPeriod = 1'b0;
            periodEnd = 1'b0;
            if (stop_i[g]) begin
                state_d = IDLE;
            end else if (startOk) begin
                count_d = '0;
                if (selPeriod == '0) begin
                    state_d = DONE;
                end else if (selDelay != '0) begin
                    state_d = DELAY;
                    timer_d = selDelay;
                end else begin
                    newPeriod = 1'b1;
                end
            end else if (tick) begin
                case (state_q)
                    DELAY: begin
                        if (timer_q == CNT_W'(1)) newPeriod = 1'b1;
                        else timer_d = timer_q - CNT_W'(1);
                    end
                    HIGH: begin
                        if (timer_q != CNT_W'(1)) begin
                            timer_d = timer_q - CNT_W'(1);
                        end else if (loLen != '0) begin
                            state_d = LOW;
                            timer_d = loLen;
                        end else begin
                            periodEnd = 1'b1;
                        end
                    end
                    LOW: begin
                        if (timer_q != CNT_W'(1)) timer_d = timer_q - CNT_W'(1);
                        else periodEnd = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (periodEnd) begin
                if ((burst_q != '0) && (count_q == burst_q)) state_d = DONE;
                else newPeriod = 1'b1;
            end
            // A zero-width pulse still opens a counted period, spent entirely in LOW.
            if (newPeriod) begin
                count_d = count_d + BURST_W'(1);
                if (hiLen != '0) begin
                    state_d = HIGH;
                    timer_d = hiLen;
                end else begin
                    state_d = LOW;
                    timer_d = loLen;
                end
            end
        end

        always_comb begin
            pulse_d = (state_d == HIGH);
            busy_d  = (state_d == DELAY) || (state_d == HIGH) || (state_d == LOW);
            done_d  = done_q;
            if (startOk) done_d = 1'b0;
            if ((state_d == DONE) && ((state_q != DONE) || startOk)) done_d = 1'b1;
        end

        assign pulse_out_o[g] = pulse_q;
        assign busy_o[g]      = busy_q;
        assign done_o[g]      = done_q;
        assign countArr[g]    = count_q;
    end

    assign rd_count_o = (int'(rd_ch_i) < N_CH) ? countArr[rd_ch_i] : '0;

endmodule
